// File: rtl/activation_collector.sv
// -----------------------------------------------------------------------------
// activation_collector
//
// Collects post-ReLU activations, one per beat, into frames of WEIGHT_AMOUNT
// entries and hands complete frames downstream through a valid/ready output.
// Storage is two-deep: a fill buffer that assembles the current frame (and can
// park one complete frame as "pending"), plus the output register.
//
// Ports
//   clk          : single clock, all state on rising edge
//   rst_n        : asynchronous active-low reset
//   input_index  : position of the incoming activation within its frame
//   input_value  : incoming activation, stored unmodified
//   input_enable : index/value valid this cycle (no backpressure)
//   frame_data   : assembled frame, entry i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   frame_valid  : frame_data holds a complete frame
//   frame_ready  : downstream accepts frame_data on frame_valid && frame_ready
//   seq_error    : one-cycle pulse, index out of sequence or out of range
//   overflow     : one-cycle pulse, beat dropped because both stages were full
//   frame_count  : number of frames handed off, wraps at 16 bits
// -----------------------------------------------------------------------------
module activation_collector #(
   parameter int DATA_WIDTH    = 32,
   parameter int WEIGHT_AMOUNT = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [DATA_WIDTH-1:0]               input_index,
   input  logic [DATA_WIDTH-1:0]               input_value,
   input  logic                                input_enable,
   output logic [WEIGHT_AMOUNT*DATA_WIDTH-1:0] frame_data,
   output logic                                frame_valid,
   input  logic                                frame_ready,
   output logic                                seq_error,
   output logic                                overflow,
   output logic [15:0]                         frame_count
);

   localparam int IDX_W   = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;
   localparam int FRAME_W = WEIGHT_AMOUNT * DATA_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WEIGHT_AMOUNT - 1);

   // Fill buffer and sequencing state
   logic [DATA_WIDTH-1:0] fill_r [WEIGHT_AMOUNT];
   logic                  pending_r;
   logic [IDX_W-1:0]      expected_r;

   // Output stage and status registers
   logic [FRAME_W-1:0]    frame_data_r;
   logic                  frame_valid_r;
   logic                  seq_error_r;
   logic                  overflow_r;
   logic [15:0]           frame_count_r;

   // Control decode
   logic                  handshake_s;
   logic                  release_s;
   logic                  drop_s;
   logic                  checked_s;
   logic                  in_seq_s;
   logic                  complete_s;
   logic                  bypass_load_s;
   logic                  park_s;
   logic                  restart_s;
   logic                  seq_err_s;
   logic [IDX_W-1:0]      expected_next_s;
   logic [FRAME_W-1:0]    pending_frame_s;
   logic [FRAME_W-1:0]    completed_frame_s;

   assign frame_data  = frame_data_r;
   assign frame_valid = frame_valid_r;
   assign seq_error   = seq_error_r;
   assign overflow    = overflow_r;
   assign frame_count = frame_count_r;

   // Decode this edge's beat: drop, in-sequence accept, completion or restart
   always_comb begin
      handshake_s   = frame_valid_r & frame_ready;
      release_s     = pending_r & handshake_s;
      // A parked frame blocks new beats unless it leaves at this very edge
      drop_s        = input_enable & pending_r & ~handshake_s;
      checked_s     = input_enable & ~drop_s;
      in_seq_s      = checked_s &
                      (input_index == {{(DATA_WIDTH-IDX_W){1'b0}}, expected_r});
      // While releasing, expected is 0, so a completion cannot coincide
      complete_s    = in_seq_s & (expected_r == LAST_IDX);
      bypass_load_s = complete_s & (~frame_valid_r | handshake_s);
      park_s        = complete_s & ~bypass_load_s;
      seq_err_s     = checked_s & ~in_seq_s;
      restart_s     = seq_err_s & (input_index == {DATA_WIDTH{1'b0}});
   end

   // Next expected index
   always_comb begin
      expected_next_s = expected_r;
      if (in_seq_s) begin
         if (complete_s) begin
            expected_next_s = {IDX_W{1'b0}};
         end else begin
            expected_next_s = expected_r + IDX_W'(1);
         end
      end else if (restart_s) begin
         expected_next_s = IDX_W'(1);
      end else if (seq_err_s) begin
         expected_next_s = {IDX_W{1'b0}};
      end else begin
         expected_next_s = expected_r;
      end
   end

   // Frame images: parked frame as stored, completing frame with last entry bypassed
   always_comb begin
      pending_frame_s   = {FRAME_W{1'b0}};
      completed_frame_s = {FRAME_W{1'b0}};
      for (int i = 0; i < WEIGHT_AMOUNT; i++) begin
         pending_frame_s[i*DATA_WIDTH +: DATA_WIDTH] = fill_r[i];
         if (i == WEIGHT_AMOUNT - 1) begin
            completed_frame_s[i*DATA_WIDTH +: DATA_WIDTH] = input_value;
         end else begin
            completed_frame_s[i*DATA_WIDTH +: DATA_WIDTH] = fill_r[i];
         end
      end
   end

   // Fill buffer entry writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WEIGHT_AMOUNT; i++) begin
            fill_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (in_seq_s) begin
         fill_r[expected_r] <= input_value;
      end else if (restart_s) begin
         fill_r[0] <= input_value;
      end else begin
         fill_r <= fill_r;
      end
   end

   // Sequencing state: expected index and pending flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expected_r <= {IDX_W{1'b0}};
         pending_r  <= 1'b0;
      end else begin
         expected_r <= expected_next_s;
         if (release_s) begin
            pending_r <= 1'b0;
         end else if (park_s) begin
            pending_r <= 1'b1;
         end else begin
            pending_r <= pending_r;
         end
      end
   end

   // Output register: load parked or completing frame, clear on empty handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_data_r  <= {FRAME_W{1'b0}};
         frame_valid_r <= 1'b0;
      end else if (release_s) begin
         frame_data_r  <= pending_frame_s;
         frame_valid_r <= 1'b1;
      end else if (bypass_load_s) begin
         frame_data_r  <= completed_frame_s;
         frame_valid_r <= 1'b1;
      end else if (handshake_s) begin
         frame_valid_r <= 1'b0;
      end else begin
         frame_data_r  <= frame_data_r;
         frame_valid_r <= frame_valid_r;
      end
   end

   // Status pulses and hand-off counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_error_r   <= 1'b0;
         overflow_r    <= 1'b0;
         frame_count_r <= 16'd0;
      end else begin
         seq_error_r <= seq_err_s;
         overflow_r  <= drop_s;
         if (handshake_s) begin
            frame_count_r <= frame_count_r + 16'd1;
         end else begin
            frame_count_r <= frame_count_r;
         end
      end
   end

endmodule

// File: tb/tb_activation_collector.sv
module tb_activation_collector;

   localparam int DW = 32;
   localparam int WA = 4;
   localparam int FW = DW * WA;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] input_index;
   logic [DW-1:0] input_value;
   logic          input_enable;
   logic [FW-1:0] frame_data;
   logic          frame_valid;
   logic          frame_ready;
   logic          seq_error;
   logic          overflow;
   logic [15:0]   frame_count;

   activation_collector #(.DATA_WIDTH(DW), .WEIGHT_AMOUNT(WA)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .input_index  (input_index),
      .input_value  (input_value),
      .input_enable (input_enable),
      .frame_data   (frame_data),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .seq_error    (seq_error),
      .overflow     (overflow),
      .frame_count  (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int errors = 0;

   // Reference model: list of values of the frame being built, and a queue
   // of complete frames (head = frame shown on the output, second = parked).
   logic [DW-1:0] partial[$];
   logic [FW-1:0] frames_q[$];
   logic [15:0]   exp_count;
   bit            exp_err;
   bit            exp_ovf;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] pack_partial();
      logic [FW-1:0] f;
      f = '0;
      for (int i = 0; i < partial.size(); i++) f[i*DW +: DW] = partial[i];
      return f;
   endfunction

   task automatic model_reset();
      partial.delete();
      frames_q.delete();
      exp_count = 16'd0;
      exp_err   = 1'b0;
      exp_ovf   = 1'b0;
   endtask

   task automatic model_edge(input bit en, input logic [DW-1:0] idx,
                             input logic [DW-1:0] val, input bit rdy);
      bit hs;
      bit full;
      hs      = (frames_q.size() > 0) && rdy;
      full    = (frames_q.size() == 2);
      exp_err = 1'b0;
      exp_ovf = 1'b0;
      if (hs) begin
         void'(frames_q.pop_front());
         exp_count = exp_count + 16'd1;
      end
      if (en && full && !hs) begin
         exp_ovf = 1'b1;
      end else if (en) begin
         if (idx == DW'(partial.size())) begin
            partial.push_back(val);
            if (partial.size() == WA) begin
               frames_q.push_back(pack_partial());
               partial.delete();
            end
         end else begin
            exp_err = 1'b1;
            partial.delete();
            if (idx == '0) partial.push_back(val);
         end
      end
   endtask

   task automatic compare_all();
      check("seq_error", FW'(seq_error), FW'(exp_err));
      check("overflow", FW'(overflow), FW'(exp_ovf));
      check("frame_valid", FW'(frame_valid), FW'(frames_q.size() > 0));
      if (frames_q.size() > 0) check("frame_data", frame_data, frames_q[0]);
      check("frame_count", FW'(frame_count), FW'(exp_count));
   endtask

   // One clock: drive, let the edge happen, advance the model, check #1 later
   task automatic step(input bit en, input logic [DW-1:0] idx,
                       input logic [DW-1:0] val, input bit rdy);
      input_enable = en;
      input_index  = idx;
      input_value  = val;
      frame_ready  = rdy;
      @(posedge clk);
      model_edge(en, idx, val, rdy);
      #1;
      compare_all();
   endtask

   // Asynchronous reset in the middle of a cycle, outputs checked before any edge
   task automatic do_reset();
      input_enable = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_frame_valid", FW'(frame_valid), '0);
      check("rst_frame_data", frame_data, '0);
      check("rst_seq_error", FW'(seq_error), '0);
      check("rst_overflow", FW'(overflow), '0);
      check("rst_frame_count", FW'(frame_count), '0);
      model_reset();
      #3 rst_n = 1'b1;
   endtask

   initial begin
      logic [FW-1:0] ref_frame;
      logic [DW-1:0] ridx;
      int r;

      rst_n        = 1'b0;
      input_enable = 1'b0;
      input_index  = '0;
      input_value  = '0;
      frame_ready  = 1'b0;
      model_reset();
      #3;
      check("init_frame_valid", FW'(frame_valid), '0);
      check("init_frame_data", frame_data, '0);
      check("init_frame_count", FW'(frame_count), '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame 5,0,7,9
      step(1'b1, 32'd0, 32'd5, 1'b1);
      step(1'b1, 32'd1, 32'd0, 1'b1);
      step(1'b1, 32'd2, 32'd7, 1'b1);
      step(1'b1, 32'd3, 32'd9, 1'b1);
      ref_frame = {32'd9, 32'd7, 32'd0, 32'd5};
      check("basic_valid", FW'(frame_valid), FW'(1'b1));
      check("basic_data", frame_data, ref_frame);
      step(1'b0, 32'd0, 32'd0, 1'b1);
      check("basic_count", FW'(frame_count), FW'(16'd1));

      // Two frames with ready low, third frame's first beat overflows
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < WA; i++) step(1'b1, DW'(i), $urandom, 1'b0);
      step(1'b1, 32'd0, 32'hAAAA_5555, 1'b0);
      check("bp_overflow", FW'(overflow), FW'(1'b1));
      step(1'b0, 32'd0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b0, 32'd0, 32'd0, 1'b1);
      check("bp_count", FW'(frame_count), FW'(16'd3));
      step(1'b0, 32'd0, 32'd0, 1'b1);

      // Skip index 3 after 0,1 then a clean frame
      step(1'b1, 32'd0, 32'd11, 1'b1);
      step(1'b1, 32'd1, 32'd12, 1'b1);
      step(1'b1, 32'd3, 32'd13, 1'b1);
      check("skip_seq_error", FW'(seq_error), FW'(1'b1));
      for (int i = 0; i < WA; i++) step(1'b1, DW'(i), DW'(100 + i), 1'b1);

      // Restart mid-frame with index 0
      step(1'b1, 32'd0, 32'd21, 1'b1);
      step(1'b1, 32'd1, 32'd22, 1'b1);
      step(1'b1, 32'd0, 32'd31, 1'b1);
      check("restart_seq_error", FW'(seq_error), FW'(1'b1));
      step(1'b1, 32'd1, 32'd32, 1'b1);
      step(1'b1, 32'd2, 32'd33, 1'b1);
      step(1'b1, 32'd3, 32'd34, 1'b1);
      ref_frame = {32'd34, 32'd33, 32'd32, 32'd31};
      check("restart_data", frame_data, ref_frame);
      step(1'b0, 32'd0, 32'd0, 1'b1);

      // Out-of-range index
      step(1'b1, 32'd7, 32'd77, 1'b1);
      check("range_seq_error", FW'(seq_error), FW'(1'b1));
      step(1'b1, 32'd1, 32'd78, 1'b1);
      check("range_expect0", FW'(seq_error), FW'(1'b1));

      // Reset between idx 1 and idx 2
      step(1'b1, 32'd0, 32'd41, 1'b1);
      step(1'b1, 32'd1, 32'd42, 1'b1);
      do_reset();
      step(1'b1, 32'd2, 32'd43, 1'b1);
      check("post_rst_seq_error", FW'(seq_error), FW'(1'b1));

      // Reset mid-cycle while a frame is being held
      for (int i = 0; i < WA; i++) step(1'b1, DW'(i), $urandom, 1'b0);
      check("hold_valid", FW'(frame_valid), FW'(1'b1));
      do_reset();
      step(1'b0, 32'd0, 32'd0, 1'b1);

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7)      ridx = DW'(partial.size());
         else if (r < 8) ridx = '0;
         else if (r < 9) ridx = DW'($urandom_range(0, WA - 1));
         else            ridx = DW'($urandom_range(WA, 40));
         step($urandom_range(0, 3) != 0, ridx, $urandom,
              (n % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
         if (n == 400) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/activation_collector.md
ACTIVATION_COLLECTOR -- requirements
Module: activation_collector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of one activation value and of the index.
REQ-002 The block SHALL have parameter WEIGHT_AMOUNT, default 4, meaning the number of activations per frame (>=2).
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port input_index, input, DATA_WIDTH: position of the incoming activation within its frame.
REQ-006 Port input_value, input, DATA_WIDTH: incoming post-ReLU activation.
REQ-007 Port input_enable, input, 1: index/value valid this cycle; no backpressure, a beat is either accepted or dropped.
REQ-008 Port frame_data, output, WEIGHT_AMOUNT*DATA_WIDTH: assembled frame, entry i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-009 Port frame_valid, output, 1: frame_data holds a complete frame.
REQ-010 Port frame_ready, input, 1: downstream accepts frame_data when frame_valid && frame_ready at a rising edge.
REQ-011 Port seq_error, output, 1: one-cycle pulse, an index was out of sequence or out of range.
REQ-012 Port overflow, output, 1: one-cycle pulse, a beat was dropped because both frame storage stages were full.
REQ-013 Port frame_count, output, 16: number of frames handed off, wraps 0xFFFF->0.

Function
REQ-014 Storage SHALL be two stages: a fill buffer (WEIGHT_AMOUNT entries plus a pending flag) and an output register (frame_data/frame_valid).
REQ-015 An expected-index counter SHALL run 0..WEIGHT_AMOUNT-1; a beat is in-sequence when input_enable=1 and input_index == expected.
REQ-016 In-sequence beat with fill buffer not pending: value written to fill entry input_index; expected increments, wrapping to 0 after WEIGHT_AMOUNT-1.
REQ-017 Out-of-sequence beat (including input_index >= WEIGHT_AMOUNT): seq_error pulses the next cycle; partial frame discarded; if input_index==0 the beat is accepted as entry 0 and expected becomes 1, otherwise the beat is dropped and expected becomes 0.
REQ-018 When entry WEIGHT_AMOUNT-1 is accepted at edge k and the output register is empty or handshaking at edge k, the complete frame (incoming value bypassed into the last entry) SHALL load into frame_data at edge k; frame_valid high from edge k (latency 1 cycle from input_enable).
REQ-019 If the output register is full and not handshaking at edge k, the completed frame SHALL remain in the fill buffer with pending=1.
REQ-020 A pending frame SHALL move to the output register at the edge where frame_valid && frame_ready; frame_valid stays high (back-to-back); pending clears.
REQ-021 frame_valid SHALL fall after a handshake only when no frame is pending or completing at that edge.
REQ-022 frame_data and frame_valid SHALL be stable while frame_valid=1 and frame_ready=0.
REQ-023 Any beat arriving while pending=1 and not released that same edge SHALL be dropped, overflow pulses, expected unchanged; a beat at the releasing edge SHALL be accepted.
REQ-024 frame_count SHALL increment by 1 on every frame_valid && frame_ready edge.
REQ-025 seq_error and overflow SHALL never both pulse for the same beat; overflow takes priority.
REQ-026 input_value SHALL be stored unmodified (no sign handling).

Reset
REQ-027 rst_n=0 SHALL immediately clear frame_valid, seq_error, overflow, pending, expected, frame_count and frame_data to 0, regardless of clk.
REQ-028 Reset mid-frame SHALL discard partial and pending frames; the first beat after release must carry index 0 to be accepted in-sequence.

Verification
REQ-029 WA=4, beats idx 0..3 values 5,0,7,9 consecutive, frame_ready=1 -> frame_valid one cycle after idx 3, frame_data={9,7,0,5}, frame_count=1.
REQ-030 Two frames back-to-back, frame_ready=0 for 10 cycles -> first frame held stable, second pending; 9th beat (third frame idx 0) dropped with overflow; on ready both frames emitted consecutively, frame_count=2.
REQ-031 Beats idx 0,1,3 -> seq_error pulse after idx 3, no frame; then idx 0..3 -> one correct frame.
REQ-032 Beats idx 0,1,0,1,2,3 -> seq_error once, frame contains values of the second idx 0..3 run.
REQ-033 Beat idx 7 (>= WEIGHT_AMOUNT) -> seq_error, dropped, expected=0.
REQ-034 rst_n low between idx 1 and idx 2, and again asynchronously mid-cycle with frame_valid=1 -> all outputs 0 immediately; subsequent idx 2 beat flagged seq_error.
